pc_sequencer: RTL

Multi-cycle fetch/execute sequencer that owns the architectural PC register of the MicroMIPS core. It drives the instruction-memory request handshake and holds the fetched instruction stable while the datapath executes. On completion it commits the next-address unit's `next_pc` result. It also sequences traps (syscall, fetch timeout, misaligned target) and halt/resume, and sits between instruction memory and the next-address/decode logic.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_sequencer_fetch_watchdog.sv | 33 +++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MicroMIPS fetch/execute sequencer: state
// encoding, trap cause codes and the instruction word size.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_NONE    = 2'b00;
  localparam cause_t CAUSE_SYSCALL = 2'b01;
  localparam cause_t CAUSE_FETCH_TO = 2'b10;
  localparam cause_t CAUSE_MISALIGN = 2'b11;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/response bus between the sequencer (master)
// and instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Saturating fetch-wait counter. expired flags the enabled cycle whose
// increment would reach LIMIT, so the owner can act on that same edge.
module fetch_watchdog #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count waiting cycles; clear has priority over enable, and the count
  // never advances past LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == LIM_M1);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the architectural PC. Issues
// instruction fetches, holds the instruction during execution, commits
// next_pc and sequences syscall/timeout/misalignment traps and halt.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC      = 32'h0000_0080,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [31:0]           pc,
  input  logic [31:0]           next_pc,
  input  logic                  exec_done,
  input  logic                  trap_req,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [31:0]           epc,
  output logic [1:0]            cause,
  output logic                  halted
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] epc_q, epc_d;
  cause_t      cause_q, cause_d;

  logic in_fetch;
  logic wd_en;
  logic wd_clr;
  logic wd_expired;

  assign in_fetch = (state_q == FETCH);
  assign wd_en    = in_fetch && !imem.imem_ready;
  assign wd_clr   = in_fetch && (imem.imem_ready || wd_expired);

  fetch_watchdog #(
    .LIMIT (FETCH_TIMEOUT),
    .CNT_W (8)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-update decisions for PC, instruction and trap info.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      FETCH: begin
        // A response arriving on the limit cycle wins over the timeout.
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end else if (wd_expired) begin
          epc_d   = pc_q;
          cause_d = CAUSE_FETCH_TO;
          state_d = TRAP;
        end
      end
      EXEC: begin
        if (exec_done) begin
          // Traps outrank both commit and halt.
          if (trap_req) begin
            epc_d   = pc_q + WORD_BYTES;
            cause_d = CAUSE_SYSCALL;
            state_d = TRAP;
          end else if (next_pc[1:0] != 2'b00) begin
            epc_d   = pc_q;
            cause_d = CAUSE_MISALIGN;
            state_d = TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = halt_req ? HALT : FETCH;
          end
        end
      end
      TRAP: begin
        pc_d    = TRAP_VEC;
        state_d = FETCH;
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Architectural PC, fetched instruction and exception registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign imem.imem_req  = in_fetch;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == EXEC);
  assign halted         = (state_q == HALT);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;

endmodule
